// File: rtl/x_uart_pkg.sv
// Shared UART types and helpers for the RX and TX sides.
// Holds no logic, so it has no latency and no backpressure.
package x_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Clock cycles per bit, rounded to the nearest whole cycle.
  function automatic int clks_per_bit(input int hz, input int baud);
    return (hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/x_uart_rx_byte.sv
// 8N1 byte receiver. o_byte/o_byte_valid and o_frame_err appear one cycle after the stop sample.
// There is no backpressure: every pulse lasts one cycle. o_accept/o_shift expose the stop-sample cycle.
module x_uart_rx_byte
  import x_uart_pkg::*;
#(
  parameter int p_clk_hz = 16875000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_uart_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_accept,
  output logic [7:0] o_shift,
  output logic       o_idle
);

  localparam int CPB  = clks_per_bit(p_clk_hz, p_baud);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // The word assembler must latch on the stop-sample edge so that o_valid lines up with o_byte_valid.
  assign o_accept = (state == STOP) && (cnt == CNT_LAST) && rx_s;
  assign o_shift  = shreg;
  assign o_idle   = (state == IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_meta      <= i_uart_rx;
      rx_s         <= rx_meta;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              o_byte       <= shreg;
              o_byte_valid <= 1'b1;
              state        <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/x_uart_rx_word.sv
// UART receiver that packs 8N1 bytes into a p_length-bit word; o_valid coincides with the final o_byte_valid.
// There is no backpressure: the outputs are single-cycle pulses, and an idle timeout drops a partial word.
module x_uart_rx_word
  import x_uart_pkg::*;
#(
  parameter int p_length       = 256,
  parameter int p_clk_hz       = 16875000,
  parameter int p_baud         = 115200,
  parameter int p_timeout_bits = 20
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_uart_rx,
  output logic [p_length-1:0] o_data,
  output logic                o_valid,
  output logic [7:0]          o_byte,
  output logic                o_byte_valid,
  output logic                o_frame_err
);

  localparam int CPB    = clks_per_bit(p_clk_hz, p_baud);
  localparam int NBYTES = p_length / 8;
  localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TO_CYC = p_timeout_bits * CPB;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(NBYTES - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TO_CYC - 1);
  localparam logic [TW-1:0]  TO_SAT   = TW'(TO_CYC);

  logic                accept;
  logic                rx_idle;
  logic [7:0]          shift;
  logic [BIW-1:0]      byte_idx;
  logic [TW-1:0]       idle_cnt;
  logic [p_length-1:0] buffer;
  logic [p_length-1:0] buffer_nxt;

  x_uart_rx_byte #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_byte (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_uart_rx    (i_uart_rx),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .o_frame_err  (o_frame_err),
    .o_accept     (accept),
    .o_shift      (shift),
    .o_idle       (rx_idle)
  );

  always_comb begin
    buffer_nxt = buffer;
    buffer_nxt[byte_idx*8 +: 8] = shift;
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      byte_idx <= '0;
      idle_cnt <= '0;
      buffer   <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (accept) begin
        buffer <= buffer_nxt;
        if (byte_idx == LAST_IDX) begin
          o_data   <= buffer_nxt;
          o_valid  <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + BIW'(1);
        end
      end else if (rx_idle && (byte_idx != '0) && (idle_cnt == TO_LAST)) begin
        // A stalled host loses its partial word, which realigns the next word to lane 0.
        byte_idx <= '0;
      end
      if (!rx_idle || (byte_idx == '0)) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_SAT) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_x_uart_rx_word.sv
// Scoreboard bench for x_uart_rx_word: default 256-bit, fast-baud 256-bit, and 8-bit instances.
module tb_x_uart_rx_word;
  import x_uart_pkg::*;

  localparam int BIT_A = 146;  // round(16875000/115200)
  localparam int BIT_C = 16;   // round(16875000/1054688)
  localparam int BIT_B = 143;  // line 2% faster than the 146-cycle receiver

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic [255:0] data_a, data_c;
  logic [7:0]   data_b;
  logic v_a, v_b, v_c, bv_a, bv_b, bv_c, fe_a, fe_b, fe_c;
  logic [7:0] byte_a, byte_b, byte_c;

  logic [255:0] wq_a[$];
  logic [255:0] wq_c[$];
  logic [7:0]   wq_b[$];
  logic [7:0]   bq_a[$];
  int nbv_a = 0, nv_a = 0, nfe_a = 0, nv_b = 0, nv_c = 0, nbv_c = 0;
  int n_checks = 0, n_errs = 0;
  logic [255:0] w;

  always #5 clk = ~clk;

  x_uart_rx_word #(.p_length(256)) dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx_a), .o_data(data_a), .o_valid(v_a),
    .o_byte(byte_a), .o_byte_valid(bv_a), .o_frame_err(fe_a));

  x_uart_rx_word #(.p_length(8)) dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx_b), .o_data(data_b), .o_valid(v_b),
    .o_byte(byte_b), .o_byte_valid(bv_b), .o_frame_err(fe_b));

  x_uart_rx_word #(.p_length(256), .p_baud(1054688)) dut_c (
    .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx_c), .o_data(data_c), .o_valid(v_c),
    .o_byte(byte_c), .o_byte_valid(bv_c), .o_frame_err(fe_c));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_byte(input int d, input int bitc, input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_rx(d, frame[i]);
      repeat (bitc - 1) @(negedge clk);
    end
  endtask

  // Output monitors: pop the scoreboard whenever a DUT pulses.
  always @(negedge clk) begin
    if (nrst) begin
      if (bv_a) begin
        nbv_a++;
        check("a_byte", byte_a, (bq_a.size() > 0) ? bq_a.pop_front() : 8'hxx);
      end
      if (v_a) begin
        nv_a++;
        check("a_valid_with_byte", bv_a, 1'b1);
        check("a_word", data_a, (wq_a.size() > 0) ? wq_a.pop_front() : 256'hx);
      end
      if (fe_a) nfe_a++;
      if (bv_c) nbv_c++;
      if (v_c) begin
        nv_c++;
        check("c_word", data_c, (wq_c.size() > 0) ? wq_c.pop_front() : 256'hx);
      end
      if (v_b) begin
        nv_b++;
        check("b_valid_with_byte", bv_b, 1'b1);
        check("b_word", data_b, (wq_b.size() > 0) ? wq_b.pop_front() : 8'hxx);
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_a_data", data_a, '0);
    check("rst_a_pulses", {v_a, bv_a, fe_a}, '0);
    check("rst_a_byte", byte_a, '0);
    check("rst_a_state", dut_a.u_byte.state, IDLE);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 32 bytes 0x00..0x1F at default rate
    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(i);
    wq_a.push_back(w);
    for (int i = 0; i < 32; i++) begin
      bq_a.push_back(8'(i));
      send_byte(0, BIT_A, 8'(i), 1'b1);
    end
    repeat (200) @(negedge clk);
    check("t1_words", nv_a, 1);
    check("t1_bytes", nbv_a, 32);
    check("t1_queues", wq_a.size() + bq_a.size(), 0);
    check("t1_lo", data_a[7:0], 8'h00);
    check("t1_hi", data_a[255:248], 8'h1F);

    // 2: frame error, line held low, then a clean byte
    send_byte(0, BIT_A, 8'hA5, 1'b0);
    repeat (300) @(negedge clk);
    check("t2_ferr_pulse", nfe_a, 1);
    check("t2_no_byte", nbv_a, 32);
    check("t2_break", dut_a.u_byte.state, BREAK);
    set_rx(0, 1'b1);
    repeat (10) @(negedge clk);
    check("t2_idle", dut_a.u_byte.state, IDLE);
    bq_a.push_back(8'h5A);
    send_byte(0, BIT_A, 8'h5A, 1'b1);
    repeat (200) @(negedge clk);
    check("t2_next_byte", nbv_a, 33);
    check("t2_byte_q", bq_a.size(), 0);

    // 3: 40-cycle glitch
    set_rx(0, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_start", dut_a.u_byte.state, START);
    repeat (20) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (200) @(negedge clk);
    check("t3_no_byte", nbv_a, 33);
    check("t3_no_err", nfe_a, 1);
    check("t3_idle", dut_a.u_byte.state, IDLE);

    // 4: partial word dropped by timeout (fast instance)
    for (int i = 0; i < 5; i++) send_byte(2, BIT_C, 8'(8'h10 + i), 1'b1);
    repeat (20 * BIT_C) @(negedge clk);
    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(8'h40 + i);
    wq_c.push_back(w);
    for (int i = 0; i < 32; i++) send_byte(2, BIT_C, 8'(8'h40 + i), 1'b1);
    repeat (50) @(negedge clk);
    check("t4_words", nv_c, 1);
    check("t4_lo", data_c[7:0], 8'h40);
    check("t4_queue", wq_c.size(), 0);

    // 5: reset mid-DATA of byte 10, then a fresh stream
    for (int i = 0; i < 10; i++) send_byte(2, BIT_C, 8'(8'h80 + i), 1'b1);
    @(negedge clk);
    set_rx(2, 1'b0);
    repeat (BIT_C * 4) @(negedge clk);
    check("t5_in_data", dut_c.u_byte.state, DATA);
    nrst = 1'b0;
    @(negedge clk);
    check("t5_rst_data", data_c, '0);
    check("t5_rst_byte", byte_c, '0);
    check("t5_rst_pulses", {v_c, bv_c, fe_c}, '0);
    check("t5_rst_state", dut_c.u_byte.state, IDLE);
    nrst = 1'b1;
    set_rx(2, 1'b1);
    repeat (50) @(negedge clk);
    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(8'h60 + i);
    wq_c.push_back(w);
    for (int i = 0; i < 32; i++) send_byte(2, BIT_C, 8'(8'h60 + i), 1'b1);
    repeat (50) @(negedge clk);
    check("t5_words", nv_c, 2);
    check("t5_queue", wq_c.size(), 0);
    check("t5_bytes", nbv_c, 79);

    // 6: 8-bit words, line 2% fast, back-to-back frames
    wq_b.push_back(8'h3C);
    wq_b.push_back(8'hC3);
    send_byte(1, BIT_B, 8'h3C, 1'b1);
    send_byte(1, BIT_B, 8'hC3, 1'b1);
    repeat (200) @(negedge clk);
    check("t6_words", nv_b, 2);
    check("t6_queue", wq_b.size(), 0);
    check("t6_last", data_b, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
